// File: rtl/reg_hazard_if.sv
// Decode-to-hazard-unit bundle: issuing instruction fields in, stall/forwarding selects and
// the stall counter out.
interface reg_hazard_if #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 3,
  parameter int CNT_W  = 16
);
  localparam int SEL_W = $clog2(DEPTH + 1);

  logic              issue_valid;
  logic [ADDR_W-1:0] issue_rs;
  logic [ADDR_W-1:0] issue_rt;
  logic              issue_rs_used;
  logic              issue_rt_used;
  logic [ADDR_W-1:0] issue_rd;
  logic              issue_wr;
  logic              issue_is_load;
  logic              flush;
  logic              stall;
  logic [SEL_W-1:0]  fwd_rs_sel;
  logic [SEL_W-1:0]  fwd_rt_sel;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output issue_valid, issue_rs, issue_rt, issue_rs_used, issue_rt_used,
           issue_rd, issue_wr, issue_is_load, flush,
    input  stall, fwd_rs_sel, fwd_rt_sel, stall_cnt
  );

  modport slave (
    input  issue_valid, issue_rs, issue_rt, issue_rs_used, issue_rt_used,
           issue_rd, issue_wr, issue_is_load, flush,
    output stall, fwd_rs_sel, fwd_rt_sel, stall_cnt
  );
endinterface

// File: rtl/reg_hazard_unit.sv
// Register-number hazard unit: scoreboard of in-flight destinations, operand forwarding
// selects, load-use stall and a saturating stall-cycle counter.
module reg_hazard_unit #(
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  reg_hazard_if.slave hz
);
  localparam int SEL_W = $clog2(DEPTH + 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Scoreboard, index 0 is the youngest in-flight instruction.
  logic [DEPTH-1:0]  sb_vld_p0;
  logic [ADDR_W-1:0] sb_dest_p0 [DEPTH];
  logic              sb_load_p0 [DEPTH];
  logic [CNT_W-1:0]  cnt_p0;

  logic [SEL_W-1:0] rs_sel;
  logic [SEL_W-1:0] rt_sel;
  logic             rs_lu;
  logic             rt_lu;
  logic             stall;
  logic             ent_vld;

  // Scanning oldest to youngest lets the youngest match overwrite older ones.
  always_comb begin
    rs_sel = '0;
    rt_sel = '0;
    rs_lu  = 1'b0;
    rt_lu  = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (sb_vld_p0[i] && sb_dest_p0[i] == hz.issue_rs && hz.issue_rs != '0 && hz.issue_rs_used) begin
        rs_sel = SEL_W'(i + 1);
        rs_lu  = sb_load_p0[i] && (i < LOAD_LAT);
      end
      if (sb_vld_p0[i] && sb_dest_p0[i] == hz.issue_rt && hz.issue_rt != '0 && hz.issue_rt_used) begin
        rt_sel = SEL_W'(i + 1);
        rt_lu  = sb_load_p0[i] && (i < LOAD_LAT);
      end
    end
  end

  assign stall   = hz.issue_valid && (rs_lu || rt_lu) && !hz.flush;
  assign ent_vld = hz.issue_valid && !stall && hz.issue_wr && (hz.issue_rd != '0);

  assign hz.stall      = stall;
  assign hz.fwd_rs_sel = hz.issue_valid ? rs_sel : '0;
  assign hz.fwd_rt_sel = hz.issue_valid ? rt_sel : '0;
  assign hz.stall_cnt  = cnt_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_vld_p0 <= '0;
      cnt_p0    <= '0;
    end else begin
      if (hz.flush) begin
        sb_vld_p0 <= '0;
      end else begin
        for (int i = DEPTH - 1; i > 0; i--) sb_vld_p0[i] <= sb_vld_p0[i-1];
        sb_vld_p0[0] <= ent_vld;
      end
      if (stall) cnt_p0 <= sat_inc(cnt_p0);
    end
  end

  // Payload fields carry no meaning while the matching valid bit is clear, so no reset.
  always_ff @(posedge clk) begin
    for (int i = DEPTH - 1; i > 0; i--) begin
      sb_dest_p0[i] <= sb_dest_p0[i-1];
      sb_load_p0[i] <= sb_load_p0[i-1];
    end
    sb_dest_p0[0] <= hz.issue_rd;
    sb_load_p0[0] <= hz.issue_is_load;
  end
endmodule
